// File: rtl/spi_slave_driver.sv
// SPI mode-0 slave front end: synchronizes the SPI pins into the clk domain,
// assembles MOSI bits into words for the receive buffer and serializes
// prefetched transmit words MSB-first on MISO.
module spi_slave_driver #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic                  spi_miso,
  output logic                  to_buf_wr,
  output logic [DATA_WIDTH-1:0] to_buf_data,
  output logic                  from_buf_oe,
  input  logic [DATA_WIDTH-1:0] from_buf_data,
  output logic                  busy,
  output logic                  frame_end
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Synchronizer chains: [0] first flop, [1] synchronized value, [2] edge history
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] cs_sync_q,   cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]  next_word_q, next_word_d;
  logic                   next_valid_q, next_valid_d;
  logic                   to_buf_wr_q, to_buf_wr_d;
  logic [DATA_WIDTH-1:0]  to_buf_data_q, to_buf_data_d;
  logic                   word_oe_q, word_oe_d;
  logic                   fetch_q, fetch_d;
  logic                   frame_end_q, frame_end_d;
  logic                   start_oe;

  // Next values of the synchronizer chains: shift each raw pin in
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[1:0],   spi_cs_n};
    mosi_sync_d = {mosi_sync_q[0],   spi_mosi};
  end

  // Synchronizer flops; idle values are sclk low, cs_n high, mosi low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  // Edge detection on synchronized signals only
  always_comb begin
    sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    mosi_bit  = mosi_sync_q[1];
  end

  // Frame FSM and datapath next-state; cs_rise overrides any sclk edge
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    next_word_d   = next_word_q;
    next_valid_d  = next_valid_q;
    to_buf_wr_d   = 1'b0;
    to_buf_data_d = to_buf_data_q;
    word_oe_d     = 1'b0;
    fetch_d       = word_oe_q;
    frame_end_d   = 1'b0;
    start_oe      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          start_oe = 1'b1;
          state_d  = LOAD;
        end
      end

      LOAD: begin
        if (cs_rise) begin
          state_d      = IDLE;
          frame_end_d  = 1'b1;
          bit_cnt_d    = '0;
          next_valid_d = 1'b0;
          rx_shift_d   = '0;
        end else begin
          // from_buf_data answers the request issued on the cs_fall cycle
          tx_shift_d   = from_buf_data;
          bit_cnt_d    = '0;
          next_valid_d = 1'b0;
          state_d      = SHIFT;
        end
      end

      SHIFT: begin
        if (cs_rise) begin
          // Partial receive word is dropped; to_buf_data keeps its value
          state_d      = IDLE;
          frame_end_d  = 1'b1;
          bit_cnt_d    = '0;
          next_valid_d = 1'b0;
          rx_shift_d   = '0;
        end else begin
          // Prefetched word arrives the cycle after the word-complete request
          if (fetch_q) begin
            next_word_d  = from_buf_data;
            next_valid_d = 1'b1;
          end
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_bit};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d     = '0;
              to_buf_wr_d   = 1'b1;
              to_buf_data_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_bit};
              word_oe_d     = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (sclk_fall) begin
            if (next_valid_q) begin
              tx_shift_d   = next_word_q;
              next_valid_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift registers, bit counter and prefetch holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      next_word_q  <= '0;
      next_valid_q <= 1'b0;
      fetch_q      <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      next_word_q  <= next_word_d;
      next_valid_q <= next_valid_d;
      fetch_q      <= fetch_d;
    end
  end

  // Registered buffer-side strobes and receive word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_buf_wr_q   <= 1'b0;
      to_buf_data_q <= '0;
      word_oe_q     <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      to_buf_wr_q   <= to_buf_wr_d;
      to_buf_data_q <= to_buf_data_d;
      word_oe_q     <= word_oe_d;
      frame_end_q   <= frame_end_d;
    end
  end

  // Output mapping; miso is forced low outside an active shift phase
  always_comb begin
    spi_miso    = (state_q == SHIFT) & tx_shift_q[DATA_WIDTH-1];
    busy        = (state_q != IDLE);
    from_buf_oe = start_oe | word_oe_q;
    to_buf_wr   = to_buf_wr_q;
    to_buf_data = to_buf_data_q;
    frame_end   = frame_end_q;
  end

endmodule

// File: tb/tb_spi_slave_driver.sv
// Directed bench for spi_slave_driver: a 32-bit instance and an 8-bit
// instance, each driven by a simple mode-0 SPI master model.
module tb_spi_slave_driver;

  localparam int HALF32 = 5;
  localparam int HALF8  = 4;

  logic        clk = 1'b0;
  logic        rst;

  logic        sclk32, mosi32, cs32, miso32, wr32, oe32, busy32, fe32;
  logic [31:0] tbd32, fbd32;
  logic        sclk8, mosi8, cs8, miso8, wr8, oe8, busy8, fe8;
  logic [7:0]  tbd8, fbd8;

  spi_slave_driver #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .spi_sclk(sclk32), .spi_mosi(mosi32), .spi_cs_n(cs32), .spi_miso(miso32),
    .to_buf_wr(wr32), .to_buf_data(tbd32),
    .from_buf_oe(oe32), .from_buf_data(fbd32),
    .busy(busy32), .frame_end(fe32)
  );

  spi_slave_driver #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .spi_sclk(sclk8), .spi_mosi(mosi8), .spi_cs_n(cs8), .spi_miso(miso8),
    .to_buf_wr(wr8), .to_buf_data(tbd8),
    .from_buf_oe(oe8), .from_buf_data(fbd8),
    .busy(busy8), .frame_end(fe8)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miscmp = 0;

  int wr32_n = 0, oe32_n = 0, fe32_n = 0;
  int wr8_n = 0, oe8_n = 0, fe8_n = 0;
  logic [31:0] rxq32 [$];
  logic [7:0]  rxq8 [$];

  // Strobe monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (wr32) begin wr32_n++; rxq32.push_back(tbd32); end
    if (oe32) oe32_n++;
    if (fe32) fe32_n++;
    if (wr8) begin wr8_n++; rxq8.push_back(tbd8); end
    if (oe8) oe8_n++;
    if (fe8) fe8_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] tx32 [0:2];
  logic [31:0] mo32 [0:2];
  logic [31:0] mi32 [0:2];
  logic [7:0]  tx8 [0:256];
  logic [7:0]  mo8 [0:255];
  logic [7:0]  mi8 [0:255];

  // One 32-bit-instance frame of nbits; optionally raise cs_n with the last rising edge
  task automatic frame32(input int nbits, input bit cs_at_last);
    for (int k = 0; k < 3; k++) mi32[k] = '0;
    fbd32 = tx32[0];
    cs32  = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      automatic int w = i / 32;
      automatic int b = i % 32;
      if (b == 1) fbd32 = tx32[w+1];
      mosi32 = mo32[w][31-b];
      repeat (HALF32) @(negedge clk);
      mi32[w] = {mi32[w][30:0], miso32};
      sclk32 = 1'b1;
      if (cs_at_last && i == nbits - 1) cs32 = 1'b1;
      repeat (HALF32) @(negedge clk);
      sclk32 = 1'b0;
    end
    if (!cs_at_last) begin
      repeat (HALF32) @(negedge clk);
      cs32 = 1'b1;
    end
    repeat (8) @(negedge clk);
  endtask

  // One 8-bit-instance frame of nwords at the minimum SCLK period
  task automatic frame8(input int nwords);
    for (int k = 0; k < 256; k++) mi8[k] = '0;
    fbd8 = tx8[0];
    cs8  = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nwords * 8; i++) begin
      automatic int w = i / 8;
      automatic int b = i % 8;
      if (b == 1) fbd8 = tx8[w+1];
      mosi8 = mo8[w][7-b];
      repeat (HALF8) @(negedge clk);
      mi8[w] = {mi8[w][6:0], miso8};
      sclk8 = 1'b1;
      repeat (HALF8) @(negedge clk);
      sclk8 = 1'b0;
    end
    repeat (HALF8) @(negedge clk);
    cs8 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int wb, ob, fb, qb;
    int bad_tx, bad_rx;

    rst = 1'b1;
    sclk32 = 1'b0; mosi32 = 1'b0; cs32 = 1'b1; fbd32 = '0;
    sclk8  = 1'b0; mosi8  = 1'b0; cs8  = 1'b1; fbd8  = '0;
    for (int k = 0; k < 3; k++) begin tx32[k] = '0; mo32[k] = '0; mi32[k] = '0; end
    for (int k = 0; k < 257; k++) tx8[k] = '0;
    for (int k = 0; k < 256; k++) begin mo8[k] = '0; mi8[k] = '0; end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_miso", 32'(miso32), 32'd0);
    check("rst_wr", 32'(wr32), 32'd0);
    check("rst_data", tbd32, 32'd0);
    check("rst_oe", 32'(oe32), 32'd0);
    check("rst_busy", 32'(busy32), 32'd0);
    check("rst_fe", 32'(fe32), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single word
    wb = wr32_n; ob = oe32_n; fb = fe32_n; qb = rxq32.size();
    tx32[0] = 32'hA5A50F0F; tx32[1] = 32'h11111111; mo32[0] = 32'h12345678;
    frame32(32, 1'b0);
    check("single_miso_word", mi32[0], 32'hA5A50F0F);
    check("single_wr_count", 32'(wr32_n - wb), 32'd1);
    check("single_rx_word", (rxq32.size() > qb) ? rxq32[qb] : 32'hxxxxxxxx, 32'h12345678);
    check("single_to_buf_data", tbd32, 32'h12345678);
    check("single_oe_count", 32'(oe32_n - ob), 32'd2);
    check("single_fe_count", 32'(fe32_n - fb), 32'd1);
    check("single_busy_after", 32'(busy32), 32'd0);

    // Back-to-back words in one frame
    wb = wr32_n; ob = oe32_n; qb = rxq32.size();
    tx32[0] = 32'h00000001; tx32[1] = 32'hFFFFFFFE; tx32[2] = 32'h22222222;
    mo32[0] = 32'hDEADBEEF; mo32[1] = 32'hCAFEF00D;
    frame32(64, 1'b0);
    check("b2b_miso_w0", mi32[0], 32'h00000001);
    check("b2b_miso_w1", mi32[1], 32'hFFFFFFFE);
    check("b2b_wr_count", 32'(wr32_n - wb), 32'd2);
    check("b2b_rx_w0", (rxq32.size() > qb) ? rxq32[qb] : 32'hxxxxxxxx, 32'hDEADBEEF);
    check("b2b_rx_w1", (rxq32.size() > qb + 1) ? rxq32[qb+1] : 32'hxxxxxxxx, 32'hCAFEF00D);
    check("b2b_oe_count", 32'(oe32_n - ob), 32'd3);

    // Abort after 13 bits, then a clean frame
    wb = wr32_n; fb = fe32_n;
    tx32[0] = 32'h55AA55AA; mo32[0] = 32'hFFFFFFFF;
    frame32(13, 1'b0);
    check("abort_wr_count", 32'(wr32_n - wb), 32'd0);
    check("abort_fe_count", 32'(fe32_n - fb), 32'd1);
    check("abort_busy", 32'(busy32), 32'd0);
    check("abort_miso", 32'(miso32), 32'd0);
    check("abort_data_kept", tbd32, 32'hCAFEF00D);
    wb = wr32_n; qb = rxq32.size();
    tx32[0] = 32'h600DF00D; mo32[0] = 32'h0BADC0DE;
    frame32(32, 1'b0);
    check("after_abort_wr_count", 32'(wr32_n - wb), 32'd1);
    check("after_abort_rx", (rxq32.size() > qb) ? rxq32[qb] : 32'hxxxxxxxx, 32'h0BADC0DE);
    check("after_abort_miso_word", mi32[0], 32'h600DF00D);

    // cs_n rise coincides with the last sclk rise
    wb = wr32_n; fb = fe32_n;
    tx32[0] = 32'h0F0F0F0F; mo32[0] = 32'h87654321;
    frame32(32, 1'b1);
    check("simul_wr_count", 32'(wr32_n - wb), 32'd0);
    check("simul_fe_count", 32'(fe32_n - fb), 32'd1);
    check("simul_busy", 32'(busy32), 32'd0);
    check("simul_data_kept", tbd32, 32'h0BADC0DE);

    // Reset in the middle of a shift with random pins
    fbd32 = 32'h13579BDF;
    cs32 = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      mosi32 = 1'($urandom());
      repeat (HALF32) @(negedge clk);
      sclk32 = 1'b1;
      repeat (HALF32) @(negedge clk);
      sclk32 = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 32'(busy32), 32'd1);
    rst = 1'b1;
    mosi32 = 1'($urandom());
    sclk32 = 1'($urandom());
    #1;
    check("mid_rst_miso", 32'(miso32), 32'd0);
    check("mid_rst_wr", 32'(wr32), 32'd0);
    check("mid_rst_data", tbd32, 32'd0);
    check("mid_rst_oe", 32'(oe32), 32'd0);
    check("mid_rst_busy", 32'(busy32), 32'd0);
    check("mid_rst_fe", 32'(fe32), 32'd0);
    @(negedge clk);
    cs32 = 1'b1; sclk32 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wb = wr32_n; ob = oe32_n;
    repeat (20) @(negedge clk);
    check("post_rst_no_wr", 32'(wr32_n - wb), 32'd0);
    check("post_rst_no_oe", 32'(oe32_n - ob), 32'd0);
    qb = rxq32.size();
    tx32[0] = 32'h3C3CC3C3; mo32[0] = 32'h89ABCDEF;
    frame32(32, 1'b0);
    check("post_rst_wr_count", 32'(wr32_n - wb), 32'd1);
    check("post_rst_rx", (rxq32.size() > qb) ? rxq32[qb] : 32'hxxxxxxxx, 32'h89ABCDEF);
    check("post_rst_miso_word", mi32[0], 32'h3C3CC3C3);

    // 8-bit instance, single word at minimum SCLK period
    wb = wr8_n; ob = oe8_n; fb = fe8_n; qb = rxq8.size();
    tx8[0] = 8'hC3; tx8[1] = 8'h00; mo8[0] = 8'h3C;
    frame8(1);
    check("w8_miso_word", 32'(mi8[0]), 32'h000000C3);
    check("w8_to_buf_data", 32'(tbd8), 32'h0000003C);
    check("w8_wr_count", 32'(wr8_n - wb), 32'd1);
    check("w8_oe_count", 32'(oe8_n - ob), 32'd2);
    check("w8_fe_count", 32'(fe8_n - fb), 32'd1);
    check("w8_busy_after", 32'(busy8), 32'd0);

    // 8-bit instance, 256 random words in one frame
    for (int k = 0; k < 257; k++) tx8[k] = 8'($urandom());
    for (int k = 0; k < 256; k++) mo8[k] = 8'($urandom());
    wb = wr8_n; ob = oe8_n; qb = rxq8.size();
    frame8(256);
    check("w8_long_wr_count", 32'(wr8_n - wb), 32'd256);
    check("w8_long_oe_count", 32'(oe8_n - ob), 32'd257);
    bad_tx = 0; bad_rx = 0;
    for (int k = 0; k < 256; k++) begin
      if (mi8[k] !== tx8[k]) bad_tx++;
      if (rxq8.size() <= qb + k || rxq8[qb+k] !== mo8[k]) bad_rx++;
    end
    check("w8_long_tx_slips", 32'(bad_tx), 32'd0);
    check("w8_long_rx_slips", 32'(bad_rx), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
